shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Shares one single-port synchronous program/vector BRAM between three requesters:
  - the HPS ROM download writer (ioctl path),
  - the 6502 CPU,
  - the vector generator (AVG).
- Sits between hps_io and the tempest_top memory map in the clk_25 domain.
- Holds the CPU off the bus while a download is in progress.
- Guarantees no download byte is lost on a collision.

Parameters:
- AW, 14, memory address width.
- DW, 8, data width.
- STARVE_MAX, 8, cycles a pending VG request may wait before it is boosted (optional feature only).

Ports:
- clk_25  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  single-cycle download write strobe.
- dl_addr  in  AW  download address.
- dl_data  in  DW  download byte.
- dl_overrun  out  1  sticky: a dl_wr was dropped.
- cpu_hold  out  1  CPU must stall/reset.
- cpu_req  in  1  CPU access request, level, held until ack.
- cpu_we  in  1  CPU write.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_dout  out  DW  CPU read data, valid with cpu_ack.
- vg_req  in  1  vector generator read request, level.
- vg_addr  in  AW  VG address.
- vg_ack  out  1  one-cycle completion pulse.
- vg_dout  out  DW  VG read data, valid with vg_ack.
- mem_addr  out  AW  BRAM address.
- mem_we  out  1  BRAM write enable.
- mem_din  out  DW  BRAM write data.
- mem_dout  in  DW  BRAM read data, one cycle after mem_addr.

Behaviour:
- Reset values (async, RESET_n=0): state IDLE; all outputs 0 except cpu_hold=1; dl pending register cleared.
- Download capture:
  - dl_wr loads a one-entry pending register {addr, data}.
  - If dl_wr arrives while the register is already pending and not being granted in that same cycle: the new byte is dropped and dl_overrun is set.
  - dl_overrun clears only on reset or on a rising edge of dl_active.
- States:
  - IDLE: choose a grant, priority DL pending > CPU > VG.
    - DL: mem_we=1 for one cycle, clear pending, stay IDLE.
    - CPU write: mem_we=1, cpu_ack pulses next cycle, goes to ACK.
    - CPU read / VG read: drive the address, go to CAP.
  - CAP: mem_dout is valid; register it into cpu_dout or vg_dout; pulse the matching ack; go to IDLE.
  - ACK (CPU write only): pulse cpu_ack; go to IDLE.
- Latency:
  - Read: request seen in IDLE at cycle N → ack and data at N+2.
  - CPU write: ack at N+1.
  - Requesters must deassert req on the cycle after ack, otherwise a new access starts.
- A DL write arriving during CAP/ACK waits in pending and is issued in the next IDLE, ahead of CPU/VG.
- mem_addr/mem_din/mem_we are registered outputs. mem_we is never 1 outside a DL or CPU-write grant.
- cpu_hold = dl_active OR dl pending. CPU requests are ignored (never granted) while cpu_hold=1.
- If dl_active rises mid-CPU transaction, the in-flight access completes (ack still issued); later CPU requests are blocked.
- Simultaneous cpu_req and vg_req in IDLE: CPU wins. VG is served next IDLE if CPU has deasserted.
- Address/data are sampled at grant; changes afterward are ignored until ack.

Optional Feature:
- Macro SHMEM_STARVE_BOOST_EN.
- Enabled:
  - A 4-bit saturating counter increments each cycle vg_req=1 without a VG grant, and resets on VG grant.
  - When the count reaches STARVE_MAX, VG outranks CPU (DL still highest).
- Disabled: fixed priority DL > CPU > VG; no counter is synthesized.

Test Plan:
- Reset → cpu_hold=1, acks 0, mem_we 0. Release with dl_active=0 → cpu_hold=0 one cycle later.
- CPU read addr 0x1234, BRAM preloaded 0xA5 → cpu_ack and cpu_dout=0xA5 exactly 2 cycles after grant; mem_we stays 0.
- Download, dl_active=1:
  - 16 dl_wr pulses every 4 cycles to 0x0000–0x000F → memory holds all bytes; dl_overrun=0.
  - Two dl_wr in consecutive cycles during a VG CAP → first written, second dropped, dl_overrun=1.
- cpu_req and vg_req asserted together continuously (feature off) → every grant goes to CPU. Feature on → vg_ack within 8+3 cycles.
- dl_active rises the cycle after a CPU read is granted → that cpu_ack still arrives; a new cpu_req gets no ack until dl_active=0 and pending is empty.
- RESET_n pulsed low during CAP → ack never issued; state IDLE; outputs at reset values asynchronously.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Three-way arbiter for one single-port BRAM: ROM download writer > CPU > vector generator.
// Define SHMEM_STARVE_BOOST_EN to let a starved VG request outrank the CPU.
module shared_mem_arbiter #(
  parameter int unsigned AW         = 14,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk_25,
  input  logic          RESET_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_overrun,
  output logic          cpu_hold,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  input  logic          vg_req,
  input  logic [AW-1:0] vg_addr,
  output logic          vg_ack,
  output logic [DW-1:0] vg_dout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {StIdle, StCap, StAck} state_e;

  state_e        state_q;
  logic          cap_cpu_q;
  logic          cpu_ack_q, vg_ack_q, mem_we_q;
  logic [DW-1:0] cpu_dout_q, vg_dout_q, mem_din_q;
  logic [AW-1:0] mem_addr_q;

  logic          dl_pend_q, dl_pend_d;
  logic [AW-1:0] dl_paddr_q;
  logic [DW-1:0] dl_pdata_q;
  logic          dl_overrun_q, dl_active_q, cpu_hold_q;

  logic idle, hold_block, vg_boost;
  logic gnt_dl, gnt_cpu, gnt_vg, dl_drop;

  // Block the CPU as soon as a download is visible, even before cpu_hold catches up.
  assign idle       = (state_q == StIdle);
  assign hold_block = cpu_hold_q | dl_active | dl_pend_q;
  assign gnt_dl     = idle & dl_pend_q;
  assign gnt_cpu    = idle & ~dl_pend_q & cpu_req & ~hold_block & ~(vg_boost & vg_req);
  assign gnt_vg     = idle & ~dl_pend_q & vg_req & ~gnt_cpu;
  assign dl_drop    = dl_wr & dl_pend_q & ~gnt_dl;
  assign dl_pend_d  = (dl_wr & ~dl_drop) | (dl_pend_q & ~gnt_dl);

`ifdef SHMEM_STARVE_BOOST_EN
  logic [3:0] starve_q;

  always_ff @(posedge clk_25 or negedge RESET_n) begin
    if (!RESET_n) begin
      starve_q <= '0;
    end else if (gnt_vg) begin
      starve_q <= '0;
    end else if (vg_req && starve_q != 4'hF) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  assign vg_boost = (32'(starve_q) >= STARVE_MAX);
`else
  // Threshold only matters in the boost build.
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign vg_boost          = 1'b0;
`endif

  always_ff @(posedge clk_25 or negedge RESET_n) begin
    if (!RESET_n) begin
      dl_pend_q    <= 1'b0;
      dl_paddr_q   <= '0;
      dl_pdata_q   <= '0;
      dl_overrun_q <= 1'b0;
      dl_active_q  <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      dl_active_q <= dl_active;
      dl_pend_q   <= dl_pend_d;
      cpu_hold_q  <= dl_active | dl_pend_d;
      if (dl_wr && !dl_drop) begin
        dl_paddr_q <= dl_addr;
        dl_pdata_q <= dl_data;
      end
      if (dl_drop) begin
        dl_overrun_q <= 1'b1;
      end else if (dl_active && !dl_active_q) begin
        dl_overrun_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= StIdle;
      cap_cpu_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vg_ack_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_dout_q <= '0;
      vg_dout_q  <= '0;
      mem_din_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      vg_ack_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_dl) begin
            mem_addr_q <= dl_paddr_q;
            mem_din_q  <= dl_pdata_q;
            mem_we_q   <= 1'b1;
          end else if (gnt_cpu) begin
            mem_addr_q <= cpu_addr;
            cap_cpu_q  <= 1'b1;
            if (cpu_we) begin
              mem_din_q <= cpu_din;
              mem_we_q  <= 1'b1;
              cpu_ack_q <= 1'b1;
              state_q   <= StAck;
            end else begin
              state_q <= StCap;
            end
          end else if (gnt_vg) begin
            mem_addr_q <= vg_addr;
            cap_cpu_q  <= 1'b0;
            state_q    <= StCap;
          end
        end
        StCap: begin
          if (cap_cpu_q) begin
            cpu_dout_q <= mem_dout;
            cpu_ack_q  <= 1'b1;
          end else begin
            vg_dout_q <= mem_dout;
            vg_ack_q  <= 1'b1;
          end
          state_q <= StIdle;
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dl_overrun = dl_overrun_q;
  assign cpu_hold   = cpu_hold_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_dout   = cpu_dout_q;
  assign vg_ack     = vg_ack_q;
  assign vg_dout    = vg_dout_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural BRAM model.
module tb_shared_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk_25, RESET_n;
  logic          dl_active, dl_wr, dl_overrun, cpu_hold;
  logic [AW-1:0] dl_addr, cpu_addr, vg_addr, mem_addr;
  logic [DW-1:0] dl_data, cpu_din, cpu_dout, vg_dout, mem_din, mem_dout;
  logic          cpu_req, cpu_we, cpu_ack, vg_req, vg_ack, mem_we;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int tests_run, tests_failed;

  shared_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .clk_25(clk_25), .RESET_n(RESET_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_overrun(dl_overrun), .cpu_hold(cpu_hold),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .vg_req(vg_req), .vg_addr(vg_addr), .vg_ack(vg_ack), .vg_dout(vg_dout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // mem_addr is the BRAM's address register, so data follows it directly.
  always @(posedge clk_25) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
    tests_run++; if ({cpu_ack, vg_ack} !== 2'b00) begin tests_failed++; $display("FAIL reset_acks: got %b want 00", {cpu_ack, vg_ack}); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", mem_we); end
    tests_run++; if (dl_overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr: got %b want 0", dl_overrun); end
    tests_run++; if (mem_addr !== 14'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    RESET_n = 1'b1;
    tick;
    tests_run++; if (cpu_hold !== 1'b0) begin tests_failed++; $display("FAIL release_hold: got %b want 0", cpu_hold); end
  endtask

  task automatic test_cpu_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    tick;
    tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL rd_early_ack: got %b want 0", cpu_ack); end
    tests_run++; if (mem_addr !== 14'h1234) begin tests_failed++; $display("FAIL rd_addr: got %h want 1234", mem_addr); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rd_we1: got %b want 0", mem_we); end
    tick;
    tests_run++; if (cpu_ack !== 1'b1) begin tests_failed++; $display("FAIL rd_ack: got %b want 1", cpu_ack); end
    tests_run++; if (cpu_dout !== 8'hA5) begin tests_failed++; $display("FAIL rd_data: got %h want a5", cpu_dout); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rd_we2: got %b want 0", mem_we); end
    cpu_req = 1'b0;
    tick;
    tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL rd_ack_pulse: got %b want 0", cpu_ack); end
  endtask

  task automatic test_cpu_write;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_din = 8'h3C;
    tick;
    tests_run++; if ({cpu_ack, mem_we} !== 2'b11) begin tests_failed++; $display("FAIL wr_ack_we: got %b want 11", {cpu_ack, mem_we}); end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_din = 8'h00;
    tick;
    tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL wr_ack_pulse: got %b want 0", cpu_ack); end
    tests_run++; if (mem[14'h0100] !== 8'h3C) begin tests_failed++; $display("FAIL wr_mem: got %h want 3c", mem[14'h0100]); end
  endtask

  task automatic test_download;
    dl_active = 1'b1;
    tick;
    tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL dl_hold: got %b want 1", cpu_hold); end
    for (int i = 0; i < 16; i++) begin
      dl_wr = 1'b1; dl_addr = 14'(i); dl_data = 8'(8'h40 + i);
      tick;
      dl_wr = 1'b0;
      tick; tick; tick;
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (mem[i] !== 8'(8'h40 + i)) begin tests_failed++; $display("FAIL dl_mem[%0d]: got %h want %h", i, mem[i], 8'(8'h40 + i)); end
    end
    tests_run++; if (dl_overrun !== 1'b0) begin tests_failed++; $display("FAIL dl_no_ovr: got %b want 0", dl_overrun); end
  endtask

  task automatic test_overrun;
    vg_req = 1'b1; vg_addr = 14'h2000;
    dl_wr = 1'b1; dl_addr = 14'h0020; dl_data = 8'h11;
    tick;
    dl_addr = 14'h0021; dl_data = 8'h22;
    tick;
    tests_run++; if (vg_ack !== 1'b1 || vg_dout !== 8'h5A) begin tests_failed++; $display("FAIL ovr_vg: got ack %b data %h want 1 5a", vg_ack, vg_dout); end
    tests_run++; if (dl_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b want 1", dl_overrun); end
    vg_req = 1'b0; dl_wr = 1'b0;
    tick; tick;
    tests_run++; if (mem[14'h0020] !== 8'h11) begin tests_failed++; $display("FAIL ovr_first: got %h want 11", mem[14'h0020]); end
    tests_run++; if (mem[14'h0021] !== 8'h00) begin tests_failed++; $display("FAIL ovr_dropped: got %h want 00", mem[14'h0021]); end
    dl_active = 1'b0;
    tick; tick;
    tests_run++; if (dl_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b want 1", dl_overrun); end
    dl_active = 1'b1;
    tick;
    tests_run++; if (dl_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", dl_overrun); end
    dl_active = 1'b0;
    tick; tick;
  endtask

  task automatic test_priority;
    int cpu_n, vg_n, first_vg;
    cpu_n = 0; vg_n = 0; first_vg = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    vg_req = 1'b1; vg_addr = 14'h2000;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (cpu_ack) cpu_n++;
      if (vg_ack) begin
        vg_n++;
        if (first_vg == 0) first_vg = i;
      end
    end
`ifdef SHMEM_STARVE_BOOST_EN
    tests_run++; if (first_vg == 0 || first_vg > 11) begin tests_failed++; $display("FAIL boost_vg: first vg_ack at %0d want 1..11", first_vg); end
`else
    tests_run++; if (cpu_n != 10) begin tests_failed++; $display("FAIL prio_cpu: got %0d acks want 10", cpu_n); end
    tests_run++; if (vg_n != 0) begin tests_failed++; $display("FAIL prio_vg: got %0d acks want 0", vg_n); end
`endif
    cpu_req = 1'b0; vg_req = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_simultaneous;
    cpu_req = 1'b1; vg_req = 1'b1;
    tick; tick;
    tests_run++; if ({cpu_ack, vg_ack} !== 2'b10) begin tests_failed++; $display("FAIL sim_cpu_first: got %b want 10", {cpu_ack, vg_ack}); end
    cpu_req = 1'b0;
    tick;
    tests_run++; if (vg_ack !== 1'b0) begin tests_failed++; $display("FAIL sim_vg_early: got %b want 0", vg_ack); end
    tick;
    tests_run++; if (vg_ack !== 1'b1 || vg_dout !== 8'h5A) begin tests_failed++; $display("FAIL sim_vg: got ack %b data %h want 1 5a", vg_ack, vg_dout); end
    vg_req = 1'b0;
    tick;
  endtask

  task automatic test_hold_midflight;
    int seen;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    tick;
    dl_active = 1'b1;
    tick;
    tests_run++; if (cpu_ack !== 1'b1 || cpu_dout !== 8'hA5) begin tests_failed++; $display("FAIL mid_ack: got ack %b data %h want 1 a5", cpu_ack, cpu_dout); end
    cpu_req = 1'b0;
    tick;
    cpu_req = 1'b1; cpu_addr = 14'h0100;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (cpu_ack) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL mid_blocked: got %0d acks want 0", seen); end
    dl_active = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      tick;
      if (cpu_ack) seen = 1;
    end
    tests_run++; if (seen != 1 || cpu_dout !== 8'h3C) begin tests_failed++; $display("FAIL mid_resume: got ack %0d data %h want 1 3c", seen, cpu_dout); end
    cpu_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_reset_cap;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    tick;
    tests_run++; if (mem_addr !== 14'h1234) begin tests_failed++; $display("FAIL rcap_addr: got %h want 1234", mem_addr); end
    RESET_n = 1'b0;
    #1;
    tests_run++; if (cpu_ack !== 1'b0 || cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL rcap_async: got ack %b hold %b want 0 1", cpu_ack, cpu_hold); end
    tests_run++; if (mem_addr !== 14'h0) begin tests_failed++; $display("FAIL rcap_addr_clr: got %h want 0", mem_addr); end
    tick;
    tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL rcap_no_ack: got %b want 0", cpu_ack); end
    cpu_req = 1'b0;
    RESET_n = 1'b1;
    tick;
    tests_run++; if (cpu_hold !== 1'b0) begin tests_failed++; $display("FAIL rcap_hold: got %b want 0", cpu_hold); end
    cpu_req = 1'b1; cpu_addr = 14'h0100;
    tick; tick;
    tests_run++; if (cpu_ack !== 1'b1 || cpu_dout !== 8'h3C) begin tests_failed++; $display("FAIL rcap_idle: got ack %b data %h want 1 3c", cpu_ack, cpu_dout); end
    cpu_req = 1'b0;
    tick;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    RESET_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vg_req = 1'b0; vg_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[14'h1234] = 8'hA5;
    mem[14'h2000] = 8'h5A;
    test_reset;
    test_cpu_read;
    test_cpu_write;
    test_download;
    test_overrun;
    test_priority;
    test_simultaneous;
    test_hold_midflight;
    test_reset_cap;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
